// File: rtl/rnn_seq_engine_if.sv
// Streaming and parameter-load bus of the time-multiplexed Elman RNN cell.
// The slave side is the engine; the master side is whoever feeds and drains it.
interface rnn_seq_engine_if #(
  parameter int I  = 1,
  parameter int O  = 1,
  parameter int BW = 16,
  parameter int AW = 1
);
  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic [I*BW-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [O*BW-1:0]   out_vec;
  logic              out_sat;
  logic              busy;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [BW-1:0]     w_data;

  modport slave (
    input  in_valid, in_first, in_vec, out_ready, w_we, w_addr, w_data,
    output in_ready, out_valid, out_vec, out_sat, busy
  );

  modport master (
    output in_valid, in_first, in_vec, out_ready, w_we, w_addr, w_data,
    input  in_ready, out_valid, out_vec, out_sat, busy
  );
endinterface

// File: rtl/rnn_seq_engine.sv
// Elman RNN cell with a single MAC: h' = act(W_i2h*x + W_h2h*h + b_h),
// y = sat(W_h2o*h' + b_o). Weights/biases live in a runtime-writable memory.
// Hidden state persists across steps unless in_first clears it at accept.
module rnn_seq_engine #(
  parameter int INPUT_SIZE  = 1,
  parameter int HIDDEN_SIZE = 20,
  parameter int OUTPUT_SIZE = 1,
  parameter int BW          = 16,
  parameter int FRAC        = 8,
  parameter int ACT_MODE    = 0
) (
  input logic             clk,
  input logic             rst,
  rnn_seq_engine_if.slave bus
);
  localparam int I       = INPUT_SIZE;
  localparam int H       = HIDDEN_SIZE;
  localparam int O       = OUTPUT_SIZE;
  localparam int DEPTH   = H*I + H*H + H + O*H + O;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ACCW    = 2*BW + $clog2(I+H+1);
  localparam int CNT_MAX = ((I+H+1) > (H+O)) ? (I+H+1) : (H+O);
  localparam int CW      = $clog2(CNT_MAX+1);
  localparam int WH_BASE = H*I;
  localparam int BH_BASE = H*I + H*H;
  localparam int WO_BASE = H*I + H*H + H;
  localparam int BO_BASE = DEPTH - O;
  localparam int ONE_I   = 32'sd1 << FRAC;

  localparam logic [AW:0]             DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]           CNT_ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]           CNT_ZERO_C = {CW{1'b0}};
  localparam logic signed [ACCW-1:0]  SAT_MAX_C  = {{(ACCW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACCW-1:0]  SAT_MIN_C  = {{(ACCW-BW+1){1'b1}}, {(BW-1){1'b0}}};
  localparam logic signed [BW-1:0]    ONE_C      = ONE_I[BW-1:0];
  localparam logic signed [BW-1:0]    NEG_ONE_C  = -ONE_C;
  localparam logic signed [BW-1:0]    ZERO_C     = {BW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [CW-1:0]           j_r, k_r;
  int                      j_i, k_i;
  logic signed [BW-1:0]    mem_r    [DEPTH];
  logic signed [BW-1:0]    x_r      [I];
  logic signed [BW-1:0]    h_r      [H];
  logic signed [BW-1:0]    h_next_r [H];
  logic signed [BW-1:0]    out_r    [O];
  logic signed [ACCW-1:0]  acc_r;
  logic                    out_sat_r, in_ready_r, out_valid_r, busy_r;

  logic                    accept_s, wr_ok_s;
  logic                    hid_wb_s, last_hid_s, out_wb_s, last_out_s;
  logic [AW-1:0]           rd_addr_s, bias_addr_s;
  logic signed [BW-1:0]    op_a_s, w_s, b_s;
  logic signed [2*BW-1:0]  prod_s;
  logic signed [ACCW-1:0]  prod_ext_s, bias_ext_s, mac_sum_s, sh_s;
  logic signed [BW-1:0]    sat_val_s, act_val_s;
  logic                    bw_sat_s, clamp_s;

  assign j_i         = int'(j_r);
  assign k_i         = int'(k_r);
  assign accept_s    = (state_r == ST_IDLE) && bus.in_valid;
  assign wr_ok_s     = bus.w_we && !busy_r && ({1'b0, bus.w_addr} < DEPTH_C);
  assign hid_wb_s    = (state_r == ST_HID) && (k_i == I + H);
  assign last_hid_s  = hid_wb_s && (j_i == H - 1);
  assign out_wb_s    = (state_r == ST_OUT) && (k_i == H);
  assign last_out_s  = out_wb_s && (j_i == O - 1);

  assign w_s         = mem_r[rd_addr_s];
  assign b_s         = mem_r[bias_addr_s];
  assign prod_s      = $signed({{BW{op_a_s[BW-1]}}, op_a_s}) * $signed({{BW{w_s[BW-1]}}, w_s});
  assign prod_ext_s  = {{(ACCW-2*BW){prod_s[2*BW-1]}}, prod_s};
  assign bias_ext_s  = {{(ACCW-BW){b_s[BW-1]}}, b_s} <<< FRAC;
  // The bias seeds the accumulator on the first MAC of each neuron/output
  assign mac_sum_s   = ((k_i == 0) ? bias_ext_s : acc_r) + prod_ext_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.busy      = busy_r;

  // Pack the output register file onto the flat output vector
  always_comb begin
    bus.out_vec = {(O*BW){1'b0}};
    for (int n = 0; n < O; n++) begin
      bus.out_vec[n*BW +: BW] = out_r[n];
    end
  end

  // Operand and parameter-address selection for the shared MAC
  always_comb begin
    op_a_s      = ZERO_C;
    rd_addr_s   = {AW{1'b0}};
    bias_addr_s = {AW{1'b0}};
    if (state_r == ST_HID) begin
      bias_addr_s = AW'(BH_BASE + j_i);
      if (k_i < I) begin
        rd_addr_s = AW'(j_i*I + k_i);
        for (int n = 0; n < I; n++) op_a_s = (n == k_i) ? x_r[n] : op_a_s;
      end else begin
        rd_addr_s = AW'(WH_BASE + j_i*H + k_i - I);
        for (int n = 0; n < H; n++) op_a_s = (n == k_i - I) ? h_r[n] : op_a_s;
      end
    end else if (state_r == ST_OUT) begin
      bias_addr_s = AW'(BO_BASE + j_i);
      rd_addr_s   = AW'(WO_BASE + j_i*H + k_i);
      for (int n = 0; n < H; n++) op_a_s = (n == k_i) ? h_r[n] : op_a_s;
    end else begin
      op_a_s = ZERO_C;
    end
  end

  // Writeback: floor rescale, BW saturation, then the hidden activation
  always_comb begin
    sh_s      = acc_r >>> FRAC;
    bw_sat_s  = 1'b0;
    sat_val_s = sh_s[BW-1:0];
    if (sh_s > SAT_MAX_C) begin
      sat_val_s = SAT_MAX_C[BW-1:0];
      bw_sat_s  = 1'b1;
    end else if (sh_s < SAT_MIN_C) begin
      sat_val_s = SAT_MIN_C[BW-1:0];
      bw_sat_s  = 1'b1;
    end else begin
      sat_val_s = sh_s[BW-1:0];
    end
    act_val_s = sat_val_s;
    clamp_s   = 1'b0;
    if (ACT_MODE == 0) begin
      if (sat_val_s > ONE_C) begin
        act_val_s = ONE_C;
        clamp_s   = 1'b1;
      end else if (sat_val_s < NEG_ONE_C) begin
        act_val_s = NEG_ONE_C;
        clamp_s   = 1'b1;
      end else begin
        act_val_s = sat_val_s;
      end
    end else begin
      act_val_s = (sat_val_s < ZERO_C) ? ZERO_C : sat_val_s;
    end
  end

  // Next-state logic: IDLE -> HID -> OUT -> DONE -> IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s     ? ST_HID  : ST_IDLE;
      ST_HID:  state_nxt_s = last_hid_s   ? ST_OUT  : ST_HID;
      ST_OUT:  state_nxt_s = last_out_s   ? ST_DONE : ST_OUT;
      ST_DONE: state_nxt_s = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Parameter memory; only writable between steps and never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[bus.w_addr] <= bus.w_data;
  end

  // Step datapath: input latch, accumulation, writebacks and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      j_r         <= CNT_ZERO_C;
      k_r         <= CNT_ZERO_C;
      acc_r       <= {ACCW{1'b0}};
      out_sat_r   <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int n = 0; n < I; n++) x_r[n]      <= ZERO_C;
      for (int n = 0; n < H; n++) h_r[n]      <= ZERO_C;
      for (int n = 0; n < H; n++) h_next_r[n] <= ZERO_C;
      for (int n = 0; n < O; n++) out_r[n]    <= ZERO_C;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int n = 0; n < I; n++) x_r[n] <= bus.in_vec[n*BW +: BW];
            if (bus.in_first) begin
              for (int n = 0; n < H; n++) h_r[n] <= ZERO_C;
            end
            j_r       <= CNT_ZERO_C;
            k_r       <= CNT_ZERO_C;
            out_sat_r <= 1'b0;
          end
        end
        ST_HID: begin
          if (hid_wb_s) begin
            for (int n = 0; n < H; n++) begin
              if (n == j_i) h_next_r[n] <= act_val_s;
            end
            out_sat_r <= out_sat_r | bw_sat_s | clamp_s;
            k_r       <= CNT_ZERO_C;
            if (last_hid_s) begin
              j_r <= CNT_ZERO_C;
              // Old h is read throughout HID; commit the new state only now
              for (int n = 0; n < H; n++) h_r[n] <= (n == j_i) ? act_val_s : h_next_r[n];
            end else begin
              j_r <= j_r + CNT_ONE_C;
            end
          end else begin
            acc_r <= mac_sum_s;
            k_r   <= k_r + CNT_ONE_C;
          end
        end
        ST_OUT: begin
          if (out_wb_s) begin
            for (int n = 0; n < O; n++) begin
              if (n == j_i) out_r[n] <= sat_val_s;
            end
            out_sat_r <= out_sat_r | bw_sat_s;
            k_r       <= CNT_ZERO_C;
            j_r       <= last_out_s ? CNT_ZERO_C : (j_r + CNT_ONE_C);
          end else begin
            acc_r <= mac_sum_s;
            k_r   <= k_r + CNT_ONE_C;
          end
        end
        ST_DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= {ACCW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_seq_engine.sv
// Self-checking bench for rnn_seq_engine (I=1, H=2, O=1, BW=16, FRAC=8, hard-tanh).
// Expected results come from an integer reference model of the Elman step.
module tb_rnn_seq_engine;
  localparam int I     = 1;
  localparam int H     = 2;
  localparam int O     = 1;
  localparam int BW    = 16;
  localparam int FRAC  = 8;
  localparam int DEPTH = H*I + H*H + H + O*H + O;
  localparam int AW    = 4;
  localparam int LAT   = H*(I+H+1) + O*(H+1);
  localparam longint SCALE = 64'sd256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rnn_seq_engine_if #(.I(I), .O(O), .BW(BW), .AW(AW)) bus ();

  rnn_seq_engine #(
    .INPUT_SIZE(I), .HIDDEN_SIZE(H), .OUTPUT_SIZE(O),
    .BW(BW), .FRAC(FRAC), .ACT_MODE(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int pm[DEPTH];
  int hm[H];

  // ---------------- reference model ----------------
  function automatic int floor_sat(input longint a, output bit s);
    longint q;
    q = a / SCALE;
    if ((a % SCALE) != 0 && a < 0) q = q - 1;
    s = 1'b0;
    if (q > 32767)       begin q = 32767;  s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    return int'(q);
  endfunction

  function automatic void model_step(input int x, input bit first, output int y, output bit sat);
    int hn[H];
    longint acc;
    int v;
    bit s;
    sat = 1'b0;
    if (first) for (int k = 0; k < H; k++) hm[k] = 0;
    for (int j = 0; j < H; j++) begin
      acc = longint'(pm[H*I + H*H + j]) * SCALE + longint'(pm[j*I]) * x;
      for (int k = 0; k < H; k++) acc += longint'(pm[H*I + j*H + k]) * hm[k];
      v = floor_sat(acc, s);
      sat |= s;
      if (v > 256)       begin v = 256;  sat = 1'b1; end
      else if (v < -256) begin v = -256; sat = 1'b1; end
      hn[j] = v;
    end
    for (int k = 0; k < H; k++) hm[k] = hn[k];
    acc = longint'(pm[DEPTH-1]) * SCALE;
    for (int k = 0; k < H; k++) acc += longint'(pm[H*I + H*H + H + k]) * hm[k];
    y = floor_sat(acc, s);
    sat |= s;
  endfunction

  // ---------------- drivers ----------------
  function automatic int dut_out();
    return int'($signed(bus.out_vec[BW-1:0]));
  endfunction

  task automatic wr(input int addr, input int data);
    bus.w_we   = 1'b1;
    bus.w_addr = addr[AW-1:0];
    bus.w_data = data[BW-1:0];
    @(posedge clk); #1;
    bus.w_we   = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < DEPTH; a++) wr(a, pm[a]);
  endtask

  task automatic set_basic();
    pm = '{128, -64, 128, 0, 0, 128, 0, 0, 256, 256, 0};
  endtask

  task automatic start_step(input int x, input bit first);
    bus.in_vec   = x[BW-1:0];
    bus.in_first = first;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    bit ok;
    lat = 0;
    ok  = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!ok) $display("FAIL wait_valid: out_valid not seen, waited 200 cycles, required <= %0d", LAT);
    else pass_cnt++;
  endtask

  task automatic finish_hs();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_step(input int x, input bit first, output int y, output bit s, output int lat);
    start_step(x, first);
    wait_valid(lat);
    y = dut_out();
    s = bus.out_sat;
    finish_hs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < H; k++) hm[k] = 0;
    chk_cnt++; if (bus.in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);  else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", bus.busy);           else pass_cnt++;
    chk_cnt++; if (bus.out_vec !== 16'h0)  $display("FAIL reset_out_vec: got %h want 0", bus.out_vec);    else pass_cnt++;
    chk_cnt++; if (bus.out_sat !== 1'b0)   $display("FAIL reset_out_sat: got %b want 0", bus.out_sat);     else pass_cnt++;
  endtask

  task automatic test_basic();
    int y, ey, lat; bit s, es;
    bit firsts[3] = '{1'b1, 1'b0, 1'b1};
    set_basic();
    load_all();
    for (int n = 0; n < 3; n++) begin
      model_step(256, firsts[n], ey, es);
      run_step(256, firsts[n], y, s, lat);
      chk_cnt++; if (lat !== LAT) $display("FAIL basic_latency[%0d]: got %0d want %0d", n, lat, LAT); else pass_cnt++;
      chk_cnt++; if (y !== ey)    $display("FAIL basic_out[%0d]: got %0d want %0d", n, y, ey);        else pass_cnt++;
      chk_cnt++; if (s !== es)    $display("FAIL basic_sat[%0d]: got %b want %b", n, s, es);          else pass_cnt++;
    end
  endtask

  task automatic test_clamp();
    int y, ey, lat; bit s, es;
    model_step(1024, 1'b1, ey, es);
    run_step(1024, 1'b1, y, s, lat);
    chk_cnt++; if (y !== ey) $display("FAIL clamp_out: got %0d want %0d", y, ey); else pass_cnt++;
    chk_cnt++; if (s !== es) $display("FAIL clamp_sat: got %b want %b", s, es);   else pass_cnt++;
  endtask

  task automatic test_out_saturation();
    int y, ey, lat; bit s, es;
    pm[0] = 256;   pm[1] = 256;
    pm[8] = 32767; pm[9] = 32767; pm[10] = 32767;
    wr(0, 256); wr(1, 256); wr(8, 32767); wr(9, 32767); wr(10, 32767);
    model_step(256, 1'b1, ey, es);
    run_step(256, 1'b1, y, s, lat);
    chk_cnt++; if (y !== ey) $display("FAIL outsat_out: got %0d want %0d", y, ey); else pass_cnt++;
    chk_cnt++; if (s !== es) $display("FAIL outsat_sat: got %b want %b", s, es);   else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int y, ey, lat; bit s, es;
    set_basic();
    load_all();
    model_step(256, 1'b1, ey, es);
    start_step(256, 1'b1);
    wait_valid(lat);
    for (int n = 0; n < 20; n++) begin
      bus.in_valid = 1'b1;
      bus.in_first = 1'b0;
      bus.in_vec   = 16'($urandom_range(0, 65535));
      chk_cnt++; if (dut_out() !== ey)       $display("FAIL bp_out_stable[%0d]: got %0d want %0d", n, dut_out(), ey); else pass_cnt++;
      chk_cnt++; if (bus.in_ready !== 1'b0)  $display("FAIL bp_in_ready[%0d]: got %b want 0", n, bus.in_ready);        else pass_cnt++;
      chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", n, bus.out_valid);      else pass_cnt++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    finish_hs();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1)  $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);  else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL bp_single_handshake: busy got %b want 0", bus.busy); else pass_cnt++;
    model_step(256, 1'b0, ey, es);
    run_step(256, 1'b0, y, s, lat);
    chk_cnt++; if (y !== ey) $display("FAIL bp_next_step: got %0d want %0d", y, ey); else pass_cnt++;
  endtask

  task automatic test_protected_writes();
    int y, ey, lat; bit s, es;
    model_step(256, 1'b1, ey, es);
    start_step(256, 1'b1);
    @(posedge clk); #1;
    wr(0, 0);
    wait_valid(lat);
    y = dut_out();
    finish_hs();
    chk_cnt++; if (y !== ey) $display("FAIL wr_busy_ignored: got %0d want %0d", y, ey); else pass_cnt++;
    wr(0, 0);
    pm[0] = 0;
    model_step(256, 1'b1, ey, es);
    run_step(256, 1'b1, y, s, lat);
    chk_cnt++; if (y !== ey) $display("FAIL wr_idle_applied: got %0d want %0d", y, ey); else pass_cnt++;
    wr(DEPTH + 2, 1234);
    model_step(256, 1'b1, ey, es);
    run_step(256, 1'b1, y, s, lat);
    chk_cnt++; if (y !== ey) $display("FAIL wr_out_of_range: got %0d want %0d", y, ey); else pass_cnt++;
  endtask

  task automatic test_reset_mid_step();
    int y, ey, lat; bit s, es;
    set_basic();
    load_all();
    model_step(256, 1'b1, ey, es);
    run_step(256, 1'b1, y, s, lat);
    start_step(256, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (bus.in_ready !== 1'b1)  $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);   else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0)      $display("FAIL midrst_busy: got %b want 0", bus.busy);           else pass_cnt++;
    rst = 1'b0;
    for (int k = 0; k < H; k++) hm[k] = 0;
    model_step(256, 1'b0, ey, es);
    run_step(256, 1'b0, y, s, lat);
    chk_cnt++; if (y !== ey) $display("FAIL midrst_h_zero: got %0d want %0d", y, ey); else pass_cnt++;
  endtask

  task automatic test_random();
    int y, ey, lat, x; bit s, es, first;
    for (int n = 0; n < 16; n++) begin
      if (n % 4 == 0) begin
        for (int a = 0; a < DEPTH; a++) begin
          if (n % 8 == 0) pm[a] = int'($urandom_range(0, 800)) - 400;
          else            pm[a] = int'($urandom_range(0, 65535)) - 32768;
        end
        load_all();
      end
      x     = int'($urandom_range(0, 2000)) - 1000;
      first = (n % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      model_step(x, first, ey, es);
      run_step(x, first, y, s, lat);
      chk_cnt++; if (lat !== LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); else pass_cnt++;
      chk_cnt++; if (y !== ey)    $display("FAIL rand_out[%0d]: got %0d want %0d", n, y, ey);        else pass_cnt++;
      chk_cnt++; if (s !== es)    $display("FAIL rand_sat[%0d]: got %b want %b", n, s, es);          else pass_cnt++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_vec   = 16'h0;
    bus.out_ready = 1'b0;
    bus.w_we     = 1'b0;
    bus.w_addr   = 4'h0;
    bus.w_data   = 16'h0;
    test_reset();
    test_basic();
    test_clamp();
    test_out_saturation();
    test_backpressure();
    test_protected_writes();
    test_reset_mid_step();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
